// File: rtl/sram_arbiter_ctrl_if.sv
// Requester-side bundle for the SRAM arbiter: two request ports (instruction
// fetch on port 0, load/store on port 1), their acks, shared read data and busy.
interface sram_arbiter_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              we0;
  logic              we1;
  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              ack0;
  logic              ack1;
  logic [31:0]       rdata;
  logic              busy;

  // Requester side: drives requests, observes completion.
  modport master (
    output req0, req1, addr0, addr1, we0, we1, be0, be1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, be0, be1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/sram_arbiter_ctrl.sv
// Round-robin arbiter and timing sequencer for a 16-bit asynchronous SRAM.
// Each 32-bit word access is split into two half-word SRAM cycles; writes
// skip halves whose byte enables are all clear.
//
// state  | meaning
// IDLE   | no transaction; arbitrate between req0/req1
// SETUP  | cs_n low, address (and write data) presented, strobes high
// STROBE | we_n or oe_n low for ACCESS_CYCLES cycles; reads sample at end
// HOLD   | strobes released, address/data held; advance to half 1 or finish
// ACK    | one-cycle ack pulse to the granted port, bus released
module sram_arbiter_ctrl #(
  parameter int ADDR_W        = 19,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  sram_arbiter_ctrl_if.slave bus,
  output logic            sram_cs_n,
  output logic            sram_we_n,
  output logic            sram_oe_n,
  output logic            sram_lb_n,
  output logic            sram_ub_n,
  output logic [ADDR_W:0] sram_addr,
  inout  wire  [15:0]     sram_data
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

  state_t            state, state_d;
  logic              half, half_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_grant, last_grant_d;
  logic              gnt;
  logic [31:0]       rdata_q;

  // Pin values for the upcoming state, registered so no req->pin path exists.
  logic              cs_n_d, we_n_d, oe_n_d, lb_n_d, ub_n_d;
  logic [ADDR_W:0]   sram_addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              rd_sample;

  // Next-state logic, request latching and next-cycle SRAM pin values.
  always_comb begin
    state_d      = state;
    half_d       = half;
    cnt_d        = cnt;
    port_d       = port_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant;
    gnt          = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie, the port not served last wins.
          gnt          = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
          port_d       = gnt;
          last_grant_d = gnt;
          addr_d       = gnt ? bus.addr1  : bus.addr0;
          we_d         = gnt ? bus.we1    : bus.we0;
          be_d         = gnt ? bus.be1    : bus.be0;
          wdata_d      = gnt ? bus.wdata1 : bus.wdata0;
          if (we_d && (be_d == 4'b0000)) begin
            state_d = ACK;
          end else begin
            half_d  = we_d && (be_d[1:0] == 2'b00);
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt == '0) state_d = HOLD;
        else           cnt_d   = cnt - 1'b1;
      end
      HOLD: begin
        if (!half && (!we_q || (be_q[3:2] != 2'b00))) begin
          half_d  = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    sram_addr_d = sram_addr;
    dout_d      = dout_q;
    doe_d       = 1'b0;

    case (state_d)
      SETUP: begin
        cs_n_d      = 1'b0;
        sram_addr_d = {addr_d, half_d};
        dout_d      = half_d ? wdata_d[31:16] : wdata_d[15:0];
        doe_d       = we_d;
      end
      STROBE: begin
        cs_n_d = 1'b0;
        doe_d  = we_d;
        if (we_d) begin
          we_n_d = 1'b0;
          lb_n_d = !be_d[{half_d, 1'b0}];
          ub_n_d = !be_d[{half_d, 1'b1}];
        end else begin
          oe_n_d = 1'b0;
          lb_n_d = 1'b0;
          ub_n_d = 1'b0;
        end
      end
      HOLD: begin
        // Data stays driven one cycle past the we_n rising edge.
        cs_n_d = 1'b0;
        doe_d  = we_d;
      end
      default: ;
    endcase
  end

  assign rd_sample = (state == STROBE) && (cnt == '0) && !we_q;

  // State, latched request, read data and registered SRAM pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      half       <= 1'b0;
      cnt        <= '0;
      port_q     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      last_grant <= 1'b1;
      rdata_q    <= '0;
      sram_cs_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_addr  <= '0;
      dout_q     <= '0;
      doe_q      <= 1'b0;
    end else begin
      state      <= state_d;
      half       <= half_d;
      cnt        <= cnt_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      last_grant <= last_grant_d;
      if (rd_sample) begin
        if (half) rdata_q[31:16] <= sram_data;
        else      rdata_q[15:0]  <= sram_data;
      end
      sram_cs_n  <= cs_n_d;
      sram_we_n  <= we_n_d;
      sram_oe_n  <= oe_n_d;
      sram_lb_n  <= lb_n_d;
      sram_ub_n  <= ub_n_d;
      sram_addr  <= sram_addr_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
    end
  end

  assign sram_data = doe_q ? dout_q : 16'hzzzz;

  assign bus.ack0  = (state == ACK) && !port_q;
  assign bus.ack1  = (state == ACK) &&  port_q;
  assign bus.busy  = (state != IDLE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: behavioural SRAM, reference memory image and a
// scoreboard of expected acks (port, rdata, latency, strobe cycle counts).
module tb_sram_arbiter_ctrl;
  localparam int AW = 19;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_cs_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;
  logic [AW:0] sram_addr;
  wire  [15:0] sram_data;

  sram_arbiter_ctrl_if #(.ADDR_W(AW)) bus ();

  sram_arbiter_ctrl #(.ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sram_cs_n (sram_cs_n),
    .sram_we_n (sram_we_n),
    .sram_oe_n (sram_oe_n),
    .sram_lb_n (sram_lb_n),
    .sram_ub_n (sram_ub_n),
    .sram_addr (sram_addr),
    .sram_data (sram_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural async SRAM (low 256 half-words are enough here).
  logic [15:0] mem [0:255];
  assign sram_data = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h0A] = 16'h1234;
    mem[8'h0B] = 16'hBEEF;
    mem[8'h06] = 16'h1111;
    mem[8'h07] = 16'h2222;
    forever begin
      @(posedge clk);
      if (!sram_cs_n && !sram_we_n) begin
        if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  = sram_data[7:0];
        if (!sram_ub_n) mem[sram_addr[7:0]][15:8] = sram_data[15:8];
      end
    end
  end

  // Reference image of what the SRAM should hold, and the last read word.
  logic [15:0] ref_mem [0:255];
  logic [31:0] last_rd;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          lat;
    int          ncs;
    int          noe;
    int          nwe;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t mk_exp(input int p, input logic [AW-1:0] a, input logic w,
                                  input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    int   halves;
    int   lo;
    lo = int'(a[6:0]) * 2;
    if (!w) begin
      halves  = 2;
      last_rd = {ref_mem[lo+1], ref_mem[lo]};
    end else begin
      halves = ((be[1:0] != 2'b00) ? 1 : 0) + ((be[3:2] != 2'b00) ? 1 : 0);
      if (be[0]) ref_mem[lo][7:0]    = wd[7:0];
      if (be[1]) ref_mem[lo][15:8]   = wd[15:8];
      if (be[2]) ref_mem[lo+1][7:0]  = wd[23:16];
      if (be[3]) ref_mem[lo+1][15:8] = wd[31:24];
    end
    e.port  = p;
    e.rdata = last_rd;
    e.lat   = (halves == 0) ? 1 : halves * (AC + 2) + 1;
    e.ncs   = halves * (AC + 2);
    e.noe   = w ? 0 : 2 * AC;
    e.nwe   = w ? halves * AC : 0;
    return e;
  endfunction

  // Monitor: per-transaction strobe counts and ack scoreboard.
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        busy_prev = 1'b0;
  int          g_cyc, ncs, noe, nwe;
  logic [AW:0] we_addr;
  logic        we_lb, we_ub;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.busy && !busy_prev) begin
        g_cyc = cyc;
        ncs = 0; noe = 0; nwe = 0;
      end
      if (bus.busy) begin
        if (!sram_cs_n) ncs++;
        if (!sram_oe_n) noe++;
        if (!sram_we_n) begin
          nwe++;
          we_addr = sram_addr;
          we_lb   = sram_lb_n;
          we_ub   = sram_ub_n;
        end
      end
      if (bus.ack0 || bus.ack1) begin
        chk("ack_overlap", 64'(bus.ack0 & bus.ack1), 64'd0);
        chk("ack_strobes", 64'({sram_cs_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n}), 64'h1f);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", 64'(bus.ack1), 64'(e.port));
          chk("rdata", 64'(bus.rdata), 64'(e.rdata));
          chk("latency", 64'(cyc - g_cyc + 1), 64'(e.lat));
          chk("cs_cycles", 64'(ncs), 64'(e.ncs));
          chk("oe_cycles", 64'(noe), 64'(e.noe));
          chk("we_cycles", 64'(nwe), 64'(e.nwe));
        end
      end
      busy_prev = bus.busy;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic drive_port(input int p, input logic r, input logic [AW-1:0] a,
                            input logic w, input logic [3:0] be, input logic [31:0] wd);
    if (p == 0) begin
      bus.req0 = r; bus.addr0 = a; bus.we0 = w; bus.be0 = be; bus.wdata0 = wd;
    end else begin
      bus.req1 = r; bus.addr1 = a; bus.we1 = w; bus.be1 = be; bus.wdata1 = wd;
    end
  endtask

  task automatic issue(input int p, input logic [AW-1:0] a, input logic w,
                       input logic [3:0] be, input logic [31:0] wd);
    bit done = 0;
    sb.push_back(mk_exp(p, a, w, be, wd));
    @(negedge clk);
    drive_port(p, 1'b1, a, w, be, wd);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) begin
        done = 1;
        break;
      end
    end
    drive_port(p, 1'b0, a, w, be, wd);
    if (!done) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_ack;
    bit  seen;
    drive_port(0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    drive_port(1, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    ref_mem[8'h0A] = 16'h1234;
    ref_mem[8'h0B] = 16'hBEEF;
    ref_mem[8'h06] = 16'h1111;
    ref_mem[8'h07] = 16'h2222;

    do_reset();
    chk("rst_strobes", 64'({sram_cs_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n}), 64'h1f);
    chk("rst_addr", 64'(sram_addr), 64'd0);
    chk("rst_ack", 64'({bus.ack0, bus.ack1}), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);

    // Single read, port 0: halves at 0x00A/0x00B.
    issue(0, 19'h5, 1'b0, 4'h0, 32'h0);
    // Full write, port 1.
    issue(1, 19'h10, 1'b1, 4'hF, 32'hCAFEF00D);
    chk("wr_lo", 64'(mem[8'h20]), 64'(ref_mem[8'h20]));
    chk("wr_hi", 64'(mem[8'h21]), 64'h0000_0000_0000_CAFE);
    // Partial write: only half 1, low byte.
    issue(0, 19'h3, 1'b1, 4'b0100, 32'h00AB0000);
    chk("part_addr", 64'(we_addr), 64'h7);
    chk("part_lb_ub", 64'({we_lb, we_ub}), 64'b01);
    chk("part_hi", 64'(mem[8'h07]), 64'h22AB);
    chk("part_lo", 64'(mem[8'h06]), 64'h1111);
    // Empty byte enables: straight to ACK.
    issue(1, 19'h40, 1'b1, 4'h0, 32'h12345678);
    // Read back what was written.
    issue(0, 19'h10, 1'b0, 4'h0, 32'h0);
    issue(1, 19'h3, 1'b0, 4'h0, 32'h0);

    // Contention right after reset: port 0 first, then alternate.
    do_reset();
    sb.push_back(mk_exp(0, 19'h5, 1'b0, 4'h0, 32'h0));
    sb.push_back(mk_exp(1, 19'h10, 1'b0, 4'h0, 32'h0));
    sb.push_back(mk_exp(0, 19'h5, 1'b0, 4'h0, 32'h0));
    sb.push_back(mk_exp(1, 19'h10, 1'b0, 4'h0, 32'h0));
    @(negedge clk);
    drive_port(0, 1'b1, 19'h5, 1'b0, 4'h0, 32'h0);
    drive_port(1, 1'b1, 19'h10, 1'b0, 4'h0, 32'h0);
    n_ack = 0;
    for (int i = 0; i < 120 && n_ack < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) n_ack++;
    end
    drive_port(0, 1'b0, 19'h5, 1'b0, 4'h0, 32'h0);
    drive_port(1, 1'b0, 19'h10, 1'b0, 4'h0, 32'h0);
    chk("contention_acks", 64'(n_ack), 64'd4);

    // Reset during the first STROBE of a write.
    @(negedge clk);
    drive_port(0, 1'b1, 19'h30, 1'b1, 4'hF, 32'h55AA55AA);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        seen = 1;
        break;
      end
    end
    chk("mid_strobe_seen", 64'(seen), 64'd1);
    reset = 1'b1;
    drive_port(0, 1'b0, 19'h30, 1'b1, 4'hF, 32'h55AA55AA);
    @(negedge clk);
    chk("mid_rst_cs_we", 64'({sram_cs_n, sram_we_n}), 64'b11);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ack", 64'({bus.ack0, bus.ack1}), 64'd0);
    chk("mid_rst_rdata", 64'(bus.rdata), 64'd0);
    reset   = 1'b0;
    last_rd = 32'h0;
    issue(0, 19'h5, 1'b0, 4'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
